i2c_avalon_bridge_fifo: RTL and testbench
=========================================

Name: i2c_avalon_bridge_fifo

Overview:
- Parametrised Avalon-MM slave that sequences multi-byte I2C transactions on an external byte-level i2c_master.
- Provides a TX FIFO and an RX FIFO of configurable depth, a byte counter, sticky status flags, a GPIO register and a level interrupt.
- Sits between the HPS lightweight bus and one i2c_master instance.
- Software queues bytes, writes CTRL with start, then polls STATUS or waits for irq.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, 2..256).
- RX_DEPTH, 16, RX FIFO entries (power of 2, 2..256).
- GPIO_W, 3, width of GPIO output register (1..32).
- TIMEOUT_CYCLES, 100000, watchdog limit; used only with I2C_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset.
- address  in  3  Avalon word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- read  in  1  Avalon read strobe.
- readdata  out  32  Avalon read data, combinational from address.
- waitrequest  out  1  tied 0.
- irq  out  1  level interrupt.
- gpio  out  GPIO_W  GPIO register.
- m_ena  out  1  i2c_master enable.
- m_addr  out  7  slave address.
- m_rw  out  1  1=read.
- m_data_wr  out  8  byte to transmit.
- m_busy  in  1  i2c_master busy.
- m_data_rd  in  8  received byte, valid on m_busy falling edge.
- m_ack_error  in  1  NACK flag, sampled on m_busy falling edge.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - All registers, FIFOs, counters and sticky flags cleared.
  - m_ena=0, m_addr=0, m_rw=0, m_data_wr=0, irq=0, gpio=0.
- Reset mid-transaction: m_ena drops on the next edge and the FSM returns to IDLE. No done flag is set.
- Register map (reads of any unlisted address return 0xDEADBEEF):
  - 0 CTRL RW: [6:0] addr, [7] rw, [15:8] len, [16] start (write-only, self-clearing), [17] rx_flush (W), [18] tx_flush (W), [19] irq_en.
  - 1 DATA:
    - W pushes writedata[7:0] into TX.
    - R returns {rx_empty, 23'b0, RX head}. A read with RX non-empty pops the FIFO in the same cycle.
  - 2 STATUS:
    - R bits: [0] busy (FSM not IDLE), [1] ack_err, [2] done, [3] tx_full, [4] tx_empty, [5] rx_full, [6] rx_empty, [7] overflow, [8] underrun, [9] timeout, [10] start_rejected.
    - Write 1 to clear bits 1, 2, 7-10.
  - 3 LEVELS R: [15:0] TX count, [31:16] RX count.
  - 4 BYTES R: bytes completed in the current or last transaction.
  - 5 GPIO RW: [GPIO_W-1:0].
- FIFO rules:
  - Simultaneous push and pop is allowed; count is unchanged.
  - A push while full is dropped and sets overflow.
  - A pop while empty has no effect.
  - A flush empties the FIFO in one cycle and has priority over a same-cycle push.
- FSM states: IDLE, LOAD, ACTIVE, FINISH.
- IDLE:
  - start with len=0 is a no-op.
  - start while FSM is not IDLE is ignored and sets start_rejected.
  - start with len>0: clears BYTES and goes to LOAD.
  - If rw=0 and TX is empty at start: set underrun and done, stay IDLE.
- LOAD (1 cycle): drive m_addr/m_rw from CTRL. For writes, pop the TX head into m_data_wr. Assert m_ena. Go to ACTIVE.
- ACTIVE, on each m_busy rising edge:
  - BYTES++.
  - If BYTES (after increment) == len, drop m_ena.
  - Else, for writes: pop the next TX byte into m_data_wr.
  - Else, if TX is empty: drop m_ena and set underrun.
- ACTIVE, on each m_busy falling edge:
  - OR m_ack_error into ack_err.
  - For reads, push m_data_rd into RX. If RX is full, the byte is dropped and overflow is set.
  - If m_ena is already 0: go to FINISH.
- FINISH (1 cycle): set done, go to IDLE.
- Edge detection: uses a one-cycle registered copy of m_busy; edges therefore act one cycle after the input changes.
- irq = irq_en & done. It is registered and asserts the cycle after done sets.
- Concurrency: Avalon DATA/GPIO/flush accesses are permitted during a transaction. A flush during a transaction does not abort it.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- With the macro:
  - A counter runs while the FSM is not IDLE and resets on any m_busy edge.
  - Reaching TIMEOUT_CYCLES forces m_ena=0 and state IDLE, and sets timeout and done.
- Without the macro: no counter is built; STATUS[9] reads 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- Write: push 0xA1,0xB2,0xC3; CTRL addr=0x50 rw=0 len=3 start. Model toggles m_busy. -> m_data_wr sequence A1,B2,C3; m_ena drops after 3rd busy rise; done=1; BYTES=3; TX empty.
- Read: CTRL rw=1 len=2 irq_en=1; model returns 0x11,0x22. -> two DATA reads give 0x11, 0x22; third read has bit31=1; irq high until done cleared.
- Underrun: push one byte, start write len=4. -> m_ena drops after 1st busy rise; underrun=1; BYTES=1; done=1.
- Overflow: RX_DEPTH=4, read len=6 with no pops. -> RX count=4; overflow=1; first four bytes retained in order.
- Reset mid-transfer: assert reset during the 2nd byte. -> next edge m_ena=0, STATUS=0x50 (tx_empty, rx_empty), LEVELS=0; new start works normally.
- I2C_TIMEOUT_EN with TIMEOUT_CYCLES=50: start write, hold m_busy=0. -> at cycle 50 m_ena=0, timeout=1, done=1, FSM IDLE.

Source files
------------

// File: rtl/i2c_avalon_bridge_fifo_if.sv
// Avalon-MM slave bus bundle for i2c_avalon_bridge_fifo.
//   address     - word address (3 bits)
//   write/read  - access strobes
//   writedata   - write data (32 bits)
//   readdata    - read data, combinational from address (32 bits)
//   waitrequest - always 0 from this slave
// Modports: master (bus host / testbench), slave (bridge).
interface i2c_avalon_bridge_fifo_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/i2c_avalon_bridge_fifo.sv
// Avalon-MM slave that sequences multi-byte transactions on a byte-level i2c_master.
// TX/RX FIFOs, byte counter, sticky status flags, GPIO register and level irq.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   avs           - Avalon-MM slave bus (i2c_avalon_bridge_fifo_if.slave)
//   irq           - level interrupt, irq_en & done (registered)
//   gpio          - GPIO output register
//   m_ena/m_addr/m_rw/m_data_wr - i2c_master command outputs
//   m_busy/m_data_rd/m_ack_error - i2c_master status inputs
// Optional build macro: I2C_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES cycles.
module i2c_avalon_bridge_fifo #(
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned GPIO_W         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                      clock,
    input  logic                      reset,
    i2c_avalon_bridge_fifo_if.slave   avs,
    output logic                      irq,
    output logic [GPIO_W-1:0]         gpio,
    output logic                      m_ena,
    output logic [6:0]                m_addr,
    output logic                      m_rw,
    output logic [7:0]                m_data_wr,
    input  logic                      m_busy,
    input  logic [7:0]                m_data_rd,
    input  logic                      m_ack_error
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned TxCw = TxAw + 1;
    localparam int unsigned RxCw = RxAw + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StActive, StFinish} state_e;

    state_e state_q, state_d;

    // Bus decode
    logic wr_ctrl, wr_data, wr_stat, wr_gpio, rd_data, start_req;
    logic [7:0] new_len;
    logic new_rw;

    assign wr_ctrl   = avs.write && (avs.address == 3'd0);
    assign wr_data   = avs.write && (avs.address == 3'd1);
    assign wr_stat   = avs.write && (avs.address == 3'd2);
    assign wr_gpio   = avs.write && (avs.address == 3'd5);
    assign rd_data   = avs.read  && (avs.address == 3'd1);
    assign start_req = wr_ctrl && avs.writedata[16];
    assign new_len   = avs.writedata[15:8];
    assign new_rw    = avs.writedata[7];

    logic unused_wdata;
    assign unused_wdata = ^avs.writedata[31:20];

    assign avs.waitrequest = 1'b0;

    // Control / status registers
    logic [6:0] ctrl_addr_q;
    logic       ctrl_rw_q;
    logic [7:0] ctrl_len_q;
    logic       irq_en_q;
    logic [GPIO_W-1:0] gpio_q;
    logic ack_err_q, done_q, overflow_q, underrun_q, timeout_q, start_rej_q, irq_q;

    // Transaction registers
    logic       m_ena_q, m_ena_d;
    logic [6:0] m_addr_q, m_addr_d;
    logic       m_rw_q, m_rw_d;
    logic [7:0] m_data_wr_q, m_data_wr_d;
    logic [7:0] bytes_q, bytes_d;
    logic [7:0] xfer_len_q, xfer_len_d;
    logic       busy_q;

    logic busy_rise, busy_fall;
    assign busy_rise = m_busy & ~busy_q;
    assign busy_fall = ~m_busy & busy_q;

    // FIFO storage and state
    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TxAw-1:0] tx_rd_q, tx_wr_q;
    logic [TxCw-1:0] tx_cnt_q;
    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RxAw-1:0] rx_rd_q, rx_wr_q;
    logic [RxCw-1:0] rx_cnt_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    assign tx_full  = (tx_cnt_q == TxCw'(TX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RxCw'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_head  = tx_mem[tx_rd_q];
    assign rx_head  = rx_mem[rx_rd_q];

    logic tx_pop, rx_push;
    logic tx_flush, rx_flush;
    logic tx_push_ok, tx_pop_ok, tx_ovf, rx_push_ok, rx_pop_ok, rx_ovf;

    // Flush wins over any same-cycle push or pop.
    assign tx_flush   = wr_ctrl && avs.writedata[18];
    assign rx_flush   = wr_ctrl && avs.writedata[17];
    assign tx_push_ok = wr_data && !tx_full && !tx_flush;
    assign tx_ovf     = wr_data && tx_full && !tx_flush;
    assign tx_pop_ok  = tx_pop && !tx_empty && !tx_flush;
    assign rx_push_ok = rx_push && !rx_full && !rx_flush;
    assign rx_ovf     = rx_push && rx_full && !rx_flush;
    assign rx_pop_ok  = rd_data && !rx_empty && !rx_flush;

    logic set_done, set_underrun, set_ack, set_rej, set_timeout;

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_cnt_q;
    logic tmo_hit;
    assign tmo_hit = (state_q != StIdle) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || state_q == StIdle || busy_rise || busy_fall) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Transaction sequencer
    always_comb begin
        state_d      = state_q;
        m_ena_d      = m_ena_q;
        m_addr_d     = m_addr_q;
        m_rw_d       = m_rw_q;
        m_data_wr_d  = m_data_wr_q;
        bytes_d      = bytes_q;
        xfer_len_d   = xfer_len_q;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        set_done     = 1'b0;
        set_underrun = 1'b0;
        set_ack      = 1'b0;
        set_timeout  = 1'b0;
        set_rej      = start_req && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start_req && new_len != 8'd0) begin
                    bytes_d    = 8'd0;
                    xfer_len_d = new_len;
                    if (!new_rw && tx_empty) begin
                        set_underrun = 1'b1;
                        set_done     = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                m_addr_d = ctrl_addr_q;
                m_rw_d   = ctrl_rw_q;
                if (!ctrl_rw_q) begin
                    tx_pop      = 1'b1;
                    m_data_wr_d = tx_head;
                end
                m_ena_d = 1'b1;
                state_d = StActive;
            end
            StActive: begin
                // The master has latched the current byte; stage the next one or stop.
                if (busy_rise) begin
                    bytes_d = bytes_q + 8'd1;
                    if (bytes_q + 8'd1 == xfer_len_q) begin
                        m_ena_d = 1'b0;
                    end else if (!m_rw_q) begin
                        if (!tx_empty) begin
                            tx_pop      = 1'b1;
                            m_data_wr_d = tx_head;
                        end else begin
                            m_ena_d      = 1'b0;
                            set_underrun = 1'b1;
                        end
                    end
                end
                if (busy_fall) begin
                    set_ack = m_ack_error;
                    if (m_rw_q) begin
                        rx_push = 1'b1;
                    end
                    if (!m_ena_q) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                set_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef I2C_TIMEOUT_EN
        if (tmo_hit) begin
            m_ena_d     = 1'b0;
            state_d     = StIdle;
            set_done    = 1'b1;
            set_timeout = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            m_ena_q     <= 1'b0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_data_wr_q <= '0;
            bytes_q     <= '0;
            xfer_len_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_ena_q     <= m_ena_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_data_wr_q <= m_data_wr_d;
            bytes_q     <= bytes_d;
            xfer_len_q  <= xfer_len_d;
            busy_q      <= m_busy;
        end
    end

    // FIFO storage has no reset; validity is tracked by the counters.
    always_ff @(posedge clock) begin
        if (tx_push_ok) begin
            tx_mem[tx_wr_q] <= avs.writedata[7:0];
        end
        if (rx_push_ok) begin
            rx_mem[rx_wr_q] <= m_data_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || tx_flush) begin
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop_ok)  tx_rd_q <= tx_rd_q + TxAw'(1);
            tx_cnt_q <= tx_cnt_q + TxCw'(tx_push_ok) - TxCw'(tx_pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || rx_flush) begin
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push_ok) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop_ok)  rx_rd_q <= rx_rd_q + RxAw'(1);
            rx_cnt_q <= rx_cnt_q + RxCw'(rx_push_ok) - RxCw'(rx_pop_ok);
        end
    end

    // Registers and sticky flags; a same-cycle set beats a write-1-to-clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_addr_q <= '0;
            ctrl_rw_q   <= 1'b0;
            ctrl_len_q  <= '0;
            irq_en_q    <= 1'b0;
            gpio_q      <= '0;
            ack_err_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            timeout_q   <= 1'b0;
            start_rej_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_addr_q <= avs.writedata[6:0];
                ctrl_rw_q   <= avs.writedata[7];
                ctrl_len_q  <= avs.writedata[15:8];
                irq_en_q    <= avs.writedata[19];
            end
            if (wr_gpio) begin
                gpio_q <= avs.writedata[GPIO_W-1:0];
            end
            ack_err_q   <= (ack_err_q   & ~(wr_stat & avs.writedata[1]))  | set_ack;
            done_q      <= (done_q      & ~(wr_stat & avs.writedata[2]))  | set_done;
            overflow_q  <= (overflow_q  & ~(wr_stat & avs.writedata[7]))  | tx_ovf | rx_ovf;
            underrun_q  <= (underrun_q  & ~(wr_stat & avs.writedata[8]))  | set_underrun;
            timeout_q   <= (timeout_q   & ~(wr_stat & avs.writedata[9]))  | set_timeout;
            start_rej_q <= (start_rej_q & ~(wr_stat & avs.writedata[10])) | set_rej;
            irq_q       <= irq_en_q & done_q;
        end
    end

    always_comb begin
        avs.readdata = 32'hDEAD_BEEF;
        case (avs.address)
            3'd0: avs.readdata = {12'b0, irq_en_q, 3'b0, ctrl_len_q, ctrl_rw_q, ctrl_addr_q};
            3'd1: avs.readdata = {rx_empty, 23'b0, rx_head};
            3'd2: avs.readdata = {21'b0, start_rej_q, timeout_q, underrun_q, overflow_q,
                                  rx_empty, rx_full, tx_empty, tx_full, done_q, ack_err_q,
                                  state_q != StIdle};
            3'd3: avs.readdata = {16'(rx_cnt_q), 16'(tx_cnt_q)};
            3'd4: avs.readdata = {24'b0, bytes_q};
            3'd5: avs.readdata = 32'(gpio_q);
            default: avs.readdata = 32'hDEAD_BEEF;
        endcase
    end

    assign irq       = irq_q;
    assign gpio      = gpio_q;
    assign m_ena     = m_ena_q;
    assign m_addr    = m_addr_q;
    assign m_rw      = m_rw_q;
    assign m_data_wr = m_data_wr_q;

endmodule

// File: tb/tb_i2c_avalon_bridge_fifo.sv
// Directed testbench for i2c_avalon_bridge_fifo with a behavioural byte-level i2c_master.
// Build with +define+I2C_TIMEOUT_EN to include the watchdog scenario.
module tb_i2c_avalon_bridge_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       irq;
    logic [2:0] gpio;
    logic       m_ena;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_data_wr;
    logic       m_busy = 1'b0;
    logic [7:0] m_data_rd = 8'h00;
    logic       m_ack_error = 1'b0;

    i2c_avalon_bridge_fifo_if bus ();

    i2c_avalon_bridge_fifo #(
        .TX_DEPTH       (4),
        .RX_DEPTH       (4),
        .GPIO_W         (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .avs         (bus),
        .irq         (irq),
        .gpio        (gpio),
        .m_ena       (m_ena),
        .m_addr      (m_addr),
        .m_rw        (m_rw),
        .m_data_wr   (m_data_wr),
        .m_busy      (m_busy),
        .m_data_rd   (m_data_rd),
        .m_ack_error (m_ack_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] cap        [0:7];
    logic       ena_during [0:7];
    logic [7:0] rd_bytes   [0:7];
    logic       ack_bytes  [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.write     = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        #1 d = bus.readdata;
        @(negedge clock);
        bus.read    = 1'b0;
    endtask

    task automatic av_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        av_read(a, d);
        check(tag, d, exp);
    endtask

    // Byte-level i2c_master model: latches m_data_wr when it raises busy, returns
    // rd_bytes/ack_bytes on the busy fall, continues while m_ena stays high.
    task automatic i2c_serve(input int max_bytes, output int nbytes);
        int guard;
        nbytes = 0;
        guard  = 0;
        while (!m_ena && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        while (m_ena && nbytes < max_bytes) begin
            cap[nbytes] = m_data_wr;
            m_busy      = 1'b1;
            m_data_rd   = rd_bytes[nbytes];
            repeat (4) @(negedge clock);
            ena_during[nbytes] = m_ena;
            m_ack_error = ack_bytes[nbytes];
            m_busy      = 1'b0;
            nbytes++;
            repeat (3) @(negedge clock);
            m_ack_error = 1'b0;
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int n;
        logic [31:0] d;

        bus.address = 3'd0; bus.write = 1'b0; bus.writedata = 32'h0; bus.read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_bytes[i] = 8'(i + 1); ack_bytes[i] = 1'b0; cap[i] = 8'h00; ena_during[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_m_ena", 32'(m_ena), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_gpio", 32'(gpio), 32'h0);
        av_check("rst_status", 3'd2, 32'h50);
        av_check("rst_levels", 3'd3, 32'h0);
        av_check("rst_ctrl", 3'd0, 32'h0);
        av_check("unmapped", 3'd7, 32'hDEADBEEF);

        // GPIO
        av_write(3'd5, 32'hFFFF_FFFD);
        check("gpio_out", 32'(gpio), 32'h5);
        av_check("gpio_rd", 3'd5, 32'h5);

        // Write transaction of three bytes
        av_write(3'd1, 32'hA1); av_write(3'd1, 32'hB2); av_write(3'd1, 32'hC3);
        av_check("wr_levels", 3'd3, 32'h3);
        av_write(3'd0, 32'h0001_0350);
        i2c_serve(8, n);
        check("wr_nbytes", 32'(n), 32'd3);
        check("wr_byte0", 32'(cap[0]), 32'hA1);
        check("wr_byte1", 32'(cap[1]), 32'hB2);
        check("wr_byte2", 32'(cap[2]), 32'hC3);
        check("wr_ena_pattern", {29'b0, ena_during[0], ena_during[1], ena_during[2]}, 32'b110);
        check("wr_m_addr", 32'(m_addr), 32'h50);
        check("wr_m_rw", 32'(m_rw), 32'h0);
        av_check("wr_status", 3'd2, 32'h54);
        av_check("wr_bytes", 3'd4, 32'd3);
        av_write(3'd2, 32'h4);
        av_check("wr_done_clr", 3'd2, 32'h50);

        // Read transaction of two bytes with irq, NACK on the second byte
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; ack_bytes[1] = 1'b1;
        av_write(3'd0, 32'h0009_02D0);
        i2c_serve(8, n);
        ack_bytes[1] = 1'b0;
        check("rd_nbytes", 32'(n), 32'd2);
        check("rd_m_rw", 32'(m_rw), 32'h1);
        check("rd_irq", 32'(irq), 32'h1);
        av_check("rd_status", 3'd2, 32'h16);
        av_check("rd_levels", 3'd3, 32'h0002_0000);
        av_check("rd_data0", 3'd1, 32'h11);
        av_check("rd_data1", 3'd1, 32'h22);
        av_read(3'd1, d);
        check("rd_empty_bit31", 32'(d[31]), 32'h1);
        check("rd_irq_held", 32'(irq), 32'h1);
        av_write(3'd2, 32'h6);
        repeat (2) @(negedge clock);
        check("rd_irq_cleared", 32'(irq), 32'h0);

        // Underrun mid-transaction: one byte queued, len 4
        av_write(3'd1, 32'h5A);
        av_write(3'd0, 32'h0001_0450);
        i2c_serve(8, n);
        check("ur_nbytes", 32'(n), 32'd1);
        check("ur_byte0", 32'(cap[0]), 32'h5A);
        check("ur_ena_after_rise", 32'(ena_during[0]), 32'h0);
        av_check("ur_status", 3'd2, 32'h154);
        av_check("ur_bytes", 3'd4, 32'd1);
        av_write(3'd2, 32'h786);

        // Write start with empty TX: immediate underrun+done, no transaction
        av_write(3'd0, 32'h0001_0250);
        check("ur0_m_ena", 32'(m_ena), 32'h0);
        av_check("ur0_status", 3'd2, 32'h154);
        av_check("ur0_bytes", 3'd4, 32'd0);
        av_write(3'd2, 32'h786);

        // len=0 start is a no-op
        av_write(3'd1, 32'h77);
        av_write(3'd0, 32'h0001_0050);
        repeat (3) @(negedge clock);
        check("len0_m_ena", 32'(m_ena), 32'h0);
        av_check("len0_status", 3'd2, 32'h40);
        av_write(3'd0, 32'h0004_0000);

        // RX overflow: read 6 bytes into a 4-deep FIFO
        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'(i + 1);
        av_write(3'd0, 32'h0001_06D0);
        i2c_serve(8, n);
        check("ovf_nbytes", 32'(n), 32'd6);
        av_check("ovf_status", 3'd2, 32'hB4);
        av_check("ovf_levels", 3'd3, 32'h0004_0000);
        av_check("ovf_data0", 3'd1, 32'h01);
        av_check("ovf_data1", 3'd1, 32'h02);
        av_check("ovf_data2", 3'd1, 32'h03);
        av_check("ovf_data3", 3'd1, 32'h04);
        av_check("ovf_drained", 3'd3, 32'h0);
        av_write(3'd2, 32'h786);

        // TX full and overflow, then flush
        for (int i = 0; i < 5; i++) av_write(3'd1, 32'(8'hE0 + i));
        av_check("txf_levels", 3'd3, 32'h4);
        av_check("txf_status", 3'd2, 32'hC8);
        av_write(3'd0, 32'h0004_0000);
        av_check("txf_flushed", 3'd3, 32'h0);
        av_check("txf_status2", 3'd2, 32'hD0);
        av_write(3'd2, 32'h786);

        // Rejected start and reset during the second byte
        av_write(3'd1, 32'h01); av_write(3'd1, 32'h02); av_write(3'd1, 32'h03);
        av_write(3'd0, 32'h0001_0350);
        i2c_serve(1, n);
        av_write(3'd0, 32'h0001_0350);
        av_check("rej_status", 3'd2, 32'h441);
        av_check("rej_bytes", 3'd4, 32'd1);
        m_busy = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_m_ena_before", 32'(m_ena), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_m_ena", 32'(m_ena), 32'h0);
        av_check("mid_status", 3'd2, 32'h50);
        av_check("mid_levels", 3'd3, 32'h0);
        reset  = 1'b0;
        m_busy = 1'b0;
        @(negedge clock);
        av_write(3'd1, 32'h3C);
        av_write(3'd0, 32'h0001_0150);
        i2c_serve(8, n);
        check("post_nbytes", 32'(n), 32'd1);
        check("post_byte0", 32'(cap[0]), 32'h3C);
        av_check("post_status", 3'd2, 32'h54);
        av_write(3'd2, 32'h786);

`ifdef I2C_TIMEOUT_EN
        // Watchdog: master never raises busy
        av_write(3'd1, 32'h99);
        av_write(3'd0, 32'h0001_0150);
        repeat (40) @(negedge clock);
        check("tmo_m_ena_early", 32'(m_ena), 32'h1);
        repeat (15) @(negedge clock);
        check("tmo_m_ena", 32'(m_ena), 32'h0);
        av_check("tmo_status", 3'd2, 32'h254);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
